// File: rtl/vending_machine_param.sv
// Parametrised coin vending controller: edge-qualified coins, dispense with change, cancel/refund.
// Optional stock tracking with sold-out refunds is enabled by defining VEND_STOCK_EN.
module vending_machine_param #(
    parameter int PRICE      = 15,
    parameter int COIN_A     = 5,
    parameter int COIN_B     = 10,
    parameter int CW         = 6,
    parameter int STOCK_INIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    x,
    output logic          dispense,
    output logic          change_valid,
    output logic [CW-1:0] change,
    output logic          refund,
    output logic [CW-1:0] credit,
    output logic          sold_out
);

    localparam logic [CW-1:0] COIN_A_V = CW'(COIN_A);
    localparam logic [CW-1:0] COIN_B_V = CW'(COIN_B);
    localparam logic [CW-1:0] PRICE_V  = CW'(PRICE);
    localparam logic [CW:0]   PRICE_W  = (CW+1)'(PRICE);

    // Reject configurations where a coin added to a sub-price credit could overflow CW bits.
    if (PRICE <= 0 || PRICE >= (1 << CW) - COIN_B || STOCK_INIT < 0) begin : g_bad_cfg
        $error("vending_machine_param: illegal PRICE/COIN_B/CW/STOCK_INIT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_RETURN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] change_q, change_d;
    logic [1:0]    x_q;
    logic          dispense_q, dispense_d;
    logic          change_valid_q, change_valid_d;
    logic          refund_q, refund_d;

    logic          coin_ev;
    logic          cancel_ev;
    logic [CW-1:0] coin_val;
    logic [CW:0]   sum;
    logic          sold_out_w;

`ifdef VEND_STOCK_EN
    localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [SW-1:0] stock_q, stock_d;

    assign sold_out_w = (stock_q == '0);

    always_comb begin
        stock_d = stock_q;
        if (state_q == S_VEND && stock_q != '0) begin
            stock_d = stock_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stock_q <= SW'(STOCK_INIT);
        end else begin
            stock_q <= stock_d;
        end
    end
`else
    assign sold_out_w = 1'b0;
`endif

    // A code counts only on the cycle it differs from the previously sampled code.
    always_comb begin
        coin_ev   = (x == 2'b01 || x == 2'b10) && (x_q != x);
        cancel_ev = (x == 2'b11) && (x_q != 2'b11);
        coin_val  = (x == 2'b10) ? COIN_B_V : COIN_A_V;
        sum       = {1'b0, credit_q} + {1'b0, coin_val};
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        change_d       = '0;
        refund_d       = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (coin_ev && sold_out_w) begin
                    state_d        = S_RETURN;
                    credit_d       = '0;
                    refund_d       = 1'b1;
                    change_valid_d = 1'b1;
                    change_d       = coin_val;
                end else if (coin_ev) begin
                    credit_d = sum[CW-1:0];
                    if (sum >= PRICE_W) begin
                        state_d        = S_VEND;
                        dispense_d     = 1'b1;
                        change_valid_d = 1'b1;
                        change_d       = sum[CW-1:0] - PRICE_V;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else if (cancel_ev && state_q == S_COLLECT) begin
                    state_d        = S_RETURN;
                    refund_d       = 1'b1;
                    change_valid_d = 1'b1;
                    change_d       = credit_q;
                end
            end
            S_VEND, S_RETURN: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            x_q            <= 2'b00;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            refund_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            x_q            <= x;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            refund_q       <= refund_d;
        end
    end

    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign refund       = refund_q;
    assign credit       = credit_q;
    assign sold_out     = sold_out_w;

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised next-generation coin vending controller, successor to the fixed-price 2-bit-coin vending FSM in the FSM examples set.
- Configurable price, coin values and credit width. Accumulates credit, dispenses when credit reaches the price, returns change, and supports cancel/refund.
- Coin inputs are edge-qualified, so a coin held for several cycles counts once.
- Standalone block driven by a testbench or a front-panel decoder.

Parameters:
- PRICE, 15: item price in credit units; must satisfy 0 < PRICE < 2^CW - COIN_B.
- COIN_A, 5: value credited for coin code 2'b01.
- COIN_B, 10: value credited for coin code 2'b10.
- CW, 6: width of credit and change datapath.
- STOCK_INIT, 4: initial item count; used only with VEND_STOCK_EN.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- x  input  2  coin/command code: 00 idle, 01 coin A, 10 coin B, 11 cancel.
- dispense  output  1  one-cycle pulse; item released.
- change_valid  output  1  one-cycle pulse; the change value is valid.
- change  output  CW  amount returned; 0 whenever change_valid=0.
- refund  output  1  one-cycle pulse; cancel accepted, qualifies change as a refund.
- credit  output  CW  current accumulated credit.
- sold_out  output  1  high when stock is exhausted; tied 0 without VEND_STOCK_EN.

Behaviour:
- Reset: rst=0 asynchronously forces state IDLE, credit=0, x_q=2'b00, dispense=0, change_valid=0, change=0, refund=0. With the macro, stock=STOCK_INIT and sold_out=0. Reset mid-collection discards credit; no refund is issued.
- Input qualification: x_q registers x each cycle.
  - Coin event: x is 01 or 10 and x_q != x.
  - Cancel event: x=11 and x_q != 11.
  - A held code produces one event only. A direct 01->10 transition is a new event.
- States: IDLE (credit=0), COLLECT (0 < credit < PRICE), VEND (one cycle), RETURN (one cycle).
- IDLE or COLLECT, coin event at edge k: credit <= credit + value.
  - Sum >= PRICE: state VEND.
  - Sum < PRICE: state COLLECT.
- VEND, cycle after edge k: dispense=1, change_valid=1, change=credit-PRICE (0 on exact payment). Next edge: credit=0, state IDLE.
- COLLECT, cancel event: state RETURN. In RETURN: refund=1, change_valid=1, change=credit. Next edge: credit=0, state IDLE.
- IDLE, cancel event: ignored; no pulses.
- Events arriving while in VEND or RETURN are ignored; the coin is not credited.
- All outputs are decoded from registered state/credit only; no combinational path from x to any output.
- Latency: coin or cancel sampled at edge k gives a response visible in cycle k+1 and exactly one cycle wide.
- Arithmetic: unsigned, CW bits. The parameter constraint guarantees no overflow; the sum is computed at CW+1 bits and compared before truncation.

Optional Feature:
- Macro VEND_STOCK_EN.
- Defined:
  - A stock counter, $clog2(STOCK_INIT+1) bits, loads STOCK_INIT at reset and decrements on each VEND.
  - sold_out=1 when stock=0.
  - While sold_out, each coin event enters RETURN with change=coin value and refund=1; credit stays 0.
  - Cancel behaves as normal.
- Undefined: no counter, sold_out tied 0, unlimited vends.

Test Plan (defaults):
- Reset: rst=0 with x=00 for 2 cycles -> credit=0, dispense=0, change_valid=0, change=0, refund=0; release rst, no pulses for 3 cycles.
- Exact pay: x=01 for 1 cycle, 00, then 10 for 1 cycle -> credit 5 after first coin; next cycle dispense=1, change_valid=1, change=0; then credit=0.
- Overpay: 10, 00, 10 -> dispense=1, change=5 for one cycle; credit returns to 0.
- Hold and repeat: x=01 held 3 cycles, then 00 -> credit=5 only. Then 01,00,01,00 -> dispense on the third counted coin, change=0.
- Cancel: 10, 00, 11 -> refund=1, change_valid=1, change=10, dispense stays 0. Cancel from IDLE gives no pulse.
- Reset mid-operation: credit=10, then pulse rst=0 between clock edges -> credit=0 immediately, no refund/dispense after release.
- With VEND_STOCK_EN, STOCK_INIT=1: one vend then sold_out=1; next coin 01 -> refund=1, change=5, no dispense.
